// File: rtl/wb_sequencer.sv
// Writeback sequencer for a multicycle MIPS datapath.
// Takes one writeback request at a time from the main control FSM. For MDR-sourced
// writes it waits for mem_done, with a timeout. It then drives the MemToReg select and
// the register-file write strobe for exactly one cycle.
module wb_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_src,
    input  logic [4:0]       req_rd,
    input  logic             mem_done,
    input  logic             abort,
    output logic [2:0]       mem_to_reg,
    output logic [4:0]       wb_addr,
    output logic             reg_write,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] wb_count
);

    localparam logic [7:0] TmoLimit = 8'(MEM_TIMEOUT);
    localparam logic [2:0] SrcMdr   = 3'd1;
    localparam logic [2:0] SrcMax   = 3'd4;

    typedef enum logic [1:0] {StIdle, StWaitMem, StWrite} state_t;

    state_t     state;
    logic [7:0] tmo_cnt;
    logic [7:0] tmo_nxt;

    // Cycles spent in WAIT_MEM, including the current one.
    assign tmo_nxt = tmo_cnt + 8'd1;

    // Accept only in IDLE; an abort in the same cycle blocks the handshake.
    assign req_ready = (state == StIdle) && !abort && !reset;

    // Sequencer FSM with registered mux select, address and single-cycle strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            tmo_cnt    <= 8'd0;
            mem_to_reg <= 3'd0;
            wb_addr    <= 5'd0;
            reg_write  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            wb_count   <= '0;
        end else begin
            reg_write <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            if (abort) begin
                state <= StIdle;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (req_valid) begin
                            mem_to_reg <= req_src;
                            wb_addr    <= req_rd;
                            if (req_src > SrcMax) begin
                                err <= 1'b1;
                            end else if (req_src == SrcMdr) begin
                                state   <= StWaitMem;
                                tmo_cnt <= 8'd0;
                            end else begin
                                state <= StWrite;
                                done  <= 1'b1;
                                // Writes to $zero complete but never strobe the bank.
                                if (req_rd != 5'd0) begin
                                    reg_write <= 1'b1;
                                    wb_count  <= wb_count + CNT_W'(1);
                                end
                            end
                        end
                    end
                    StWaitMem: begin
                        tmo_cnt <= tmo_nxt;
                        // mem_done takes precedence over a coincident timeout.
                        if (mem_done) begin
                            state <= StWrite;
                            done  <= 1'b1;
                            if (wb_addr != 5'd0) begin
                                reg_write <= 1'b1;
                                wb_count  <= wb_count + CNT_W'(1);
                            end
                        end else if (tmo_nxt == TmoLimit) begin
                            state <= StIdle;
                            err   <= 1'b1;
                        end
                    end
                    StWrite: begin
                        state <= StIdle;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule
